// File: rtl/rom_access_arbiter.sv
// rtl/rom_access_arbiter.sv - shares the ROM array between CPU reads and HPS download writes
//
// Purpose: owns the single ROM address / write-enable / read-enable bus. CPU reads
// stall through CPU_RDYn. HPS ioctl download writes go through a one-entry buffer
// and have priority whenever the FSM is idle.
//
// Ports:
//   CLKSYS, RESET                       clock, asynchronous active-high reset
//   CPU_REQ/CPU_SEL/CPU_ADDR            CPU read request, ROM select (3 = none), address
//   CPU_DATA/CPU_RDYn                   read data, active-low ready
//   DL_ACTIVE/DL_INDEX/DL_WR            download window, target ROM, byte strobe
//   DL_ADDR/DL_DATA                     download address and byte
//   DL_WAIT/DL_OVF/DL_COUNT             buffer full, sticky lost-write flag, committed bytes
//   ROM_ADDR/ROM_WDATA/ROM_WE/ROM_RE    shared ROM bus (WE/RE one-hot per ROM)
//   ROM_Q0..ROM_Q2                      ROM read data
module rom_access_arbiter #(
    parameter int ADDR_W  = 15,
    parameter int RD_LAT  = 1,
    parameter int BOOT_AW = 9
) (
    input  logic              CLKSYS,
    input  logic              RESET,
    input  logic              CPU_REQ,
    input  logic [1:0]        CPU_SEL,
    input  logic [ADDR_W-1:0] CPU_ADDR,
    output logic [7:0]        CPU_DATA,
    output logic              CPU_RDYn,
    input  logic              DL_ACTIVE,
    input  logic [1:0]        DL_INDEX,
    input  logic              DL_WR,
    input  logic [ADDR_W-1:0] DL_ADDR,
    input  logic [7:0]        DL_DATA,
    output logic              DL_WAIT,
    output logic              DL_OVF,
    output logic [ADDR_W:0]   DL_COUNT,
    output logic [ADDR_W-1:0] ROM_ADDR,
    output logic [7:0]        ROM_WDATA,
    output logic [2:0]        ROM_WE,
    output logic [2:0]        ROM_RE,
    input  logic [7:0]        ROM_Q0,
    input  logic [7:0]        ROM_Q1,
    input  logic [7:0]        ROM_Q2
);

    typedef enum logic [2:0] {S_IDLE, S_RD, S_RDWAIT, S_RDDONE, S_WR} state_t;

    localparam logic [1:0]        LAT_INIT  = 2'(RD_LAT - 1);
    localparam logic [ADDR_W-1:0] BOOT_MASK = {{(ADDR_W-BOOT_AW){1'b0}}, {BOOT_AW{1'b1}}};

    state_t            state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [1:0]        rd_sel_q, rd_sel_d;
    logic [7:0]        cpu_data_q, cpu_data_d;
    logic              cpu_rdyn_q, cpu_rdyn_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic [7:0]        rom_wdata_q, rom_wdata_d;
    logic [2:0]        rom_we_q, rom_we_d;
    logic [2:0]        rom_re_q, rom_re_d;
    logic              buf_full_q, buf_full_d;
    logic [ADDR_W-1:0] buf_addr_q, buf_addr_d;
    logic [7:0]        buf_data_q, buf_data_d;
    logic [1:0]        buf_idx_q, buf_idx_d;
    logic              dl_ovf_q, dl_ovf_d;
    logic [ADDR_W:0]   dl_count_q, dl_count_d;
    logic              dl_active_q, dl_active_d;

    logic freeing;
    logic dl_wr_eff;
    logic dl_rise;

    // Index 3 decodes to no enable, which both blocks unmapped writes and reads.
    function automatic logic [2:0] onehot(input logic [1:0] sel);
        case (sel)
            2'd0:    onehot = 3'b001;
            2'd1:    onehot = 3'b010;
            2'd2:    onehot = 3'b100;
            default: onehot = 3'b000;
        endcase
    endfunction

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rd_sel_d    = rd_sel_q;
        cpu_data_d  = cpu_data_q;
        cpu_rdyn_d  = cpu_rdyn_q;
        rom_addr_d  = rom_addr_q;
        rom_wdata_d = rom_wdata_q;
        rom_we_d    = rom_we_q;
        rom_re_d    = rom_re_q;
        buf_full_d  = buf_full_q;
        buf_addr_d  = buf_addr_q;
        buf_data_d  = buf_data_q;
        buf_idx_d   = buf_idx_q;
        dl_ovf_d    = dl_ovf_q;
        dl_count_d  = dl_count_q;
        dl_active_d = DL_ACTIVE;

        freeing   = (state_q == S_WR);
        dl_wr_eff = DL_WR & DL_ACTIVE;
        dl_rise   = DL_ACTIVE & ~dl_active_q;

        case (state_q)
            S_IDLE: begin
                if (buf_full_q) begin
                    state_d     = S_WR;
                    rom_we_d    = onehot(buf_idx_q);
                    rom_addr_d  = buf_addr_q;
                    rom_wdata_d = buf_data_q;
                end else if (CPU_REQ && !DL_ACTIVE) begin
                    if (CPU_SEL == 2'd3) begin
                        // Unmapped: ready is asserted by RDDONE on the following cycle.
                        state_d    = S_RDDONE;
                        cpu_data_d = 8'hFF;
                    end else begin
                        state_d    = S_RD;
                        rd_sel_d   = CPU_SEL;
                        rom_re_d   = onehot(CPU_SEL);
                        rom_addr_d = (CPU_SEL == 2'd0) ? CPU_ADDR : (CPU_ADDR & BOOT_MASK);
                    end
                end
            end
            S_RD: begin
                state_d = S_RDWAIT;
                cnt_d   = LAT_INIT;
            end
            S_RDWAIT: begin
                if (cnt_q == 2'd0) begin
                    case (rd_sel_q)
                        2'd0:    cpu_data_d = ROM_Q0;
                        2'd1:    cpu_data_d = ROM_Q1;
                        default: cpu_data_d = ROM_Q2;
                    endcase
                    rom_re_d   = 3'b000;
                    cpu_rdyn_d = 1'b0;
                    state_d    = S_RDDONE;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            S_RDDONE: begin
                if (!CPU_REQ) begin
                    cpu_rdyn_d = 1'b1;
                    state_d    = S_IDLE;
                end else begin
                    cpu_rdyn_d = 1'b0;
                end
            end
            S_WR: begin
                rom_we_d   = 3'b000;
                buf_full_d = 1'b0;
                if (dl_count_q != '1) begin
                    dl_count_d = dl_count_q + (ADDR_W+1)'(1);
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // A strobe landing in the cycle the buffer drains refills it instead of being lost.
        if (dl_wr_eff) begin
            if (!buf_full_q || freeing) begin
                buf_full_d = 1'b1;
                buf_addr_d = DL_ADDR;
                buf_data_d = DL_DATA;
                buf_idx_d  = DL_INDEX;
            end else begin
                dl_ovf_d = 1'b1;
            end
        end

        if (dl_rise) begin
            dl_count_d = '0;
            dl_ovf_d   = 1'b0;
        end
    end

    always_ff @(posedge CLKSYS or posedge RESET) begin
        if (RESET) begin
            state_q     <= S_IDLE;
            cnt_q       <= 2'd0;
            rd_sel_q    <= 2'd0;
            cpu_data_q  <= 8'h00;
            cpu_rdyn_q  <= 1'b1;
            rom_addr_q  <= '0;
            rom_wdata_q <= 8'h00;
            rom_we_q    <= 3'b000;
            rom_re_q    <= 3'b000;
            buf_full_q  <= 1'b0;
            buf_addr_q  <= '0;
            buf_data_q  <= 8'h00;
            buf_idx_q   <= 2'd0;
            dl_ovf_q    <= 1'b0;
            dl_count_q  <= '0;
            dl_active_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rd_sel_q    <= rd_sel_d;
            cpu_data_q  <= cpu_data_d;
            cpu_rdyn_q  <= cpu_rdyn_d;
            rom_addr_q  <= rom_addr_d;
            rom_wdata_q <= rom_wdata_d;
            rom_we_q    <= rom_we_d;
            rom_re_q    <= rom_re_d;
            buf_full_q  <= buf_full_d;
            buf_addr_q  <= buf_addr_d;
            buf_data_q  <= buf_data_d;
            buf_idx_q   <= buf_idx_d;
            dl_ovf_q    <= dl_ovf_d;
            dl_count_q  <= dl_count_d;
            dl_active_q <= dl_active_d;
        end
    end

    assign CPU_DATA  = cpu_data_q;
    assign CPU_RDYn  = cpu_rdyn_q;
    assign ROM_ADDR  = rom_addr_q;
    assign ROM_WDATA = rom_wdata_q;
    assign ROM_WE    = rom_we_q;
    assign ROM_RE    = rom_re_q;
    assign DL_OVF    = dl_ovf_q;
    assign DL_COUNT  = dl_count_q;
    // The draining cycle accepts a new byte, so it does not ask the HPS to wait.
    assign DL_WAIT   = buf_full_q & ~freeing;

endmodule

// File: tb/tb_rom_access_arbiter.sv
// tb/tb_rom_access_arbiter.sv - directed self-checking bench for rom_access_arbiter
module tb_rom_access_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req;
    logic [1:0]  cpu_sel;
    logic [14:0] cpu_addr;
    logic [7:0]  cpu_data;
    logic        cpu_rdyn;
    logic        dl_active;
    logic [1:0]  dl_index;
    logic        dl_wr;
    logic [14:0] dl_addr;
    logic [7:0]  dl_data;
    logic        dl_wait;
    logic        dl_ovf;
    logic [15:0] dl_count;
    logic [14:0] rom_addr;
    logic [7:0]  rom_wdata;
    logic [2:0]  rom_we;
    logic [2:0]  rom_re;
    logic [7:0]  q0, q1, q2;

    int total = 0;
    int bad = 0;
    int we_pulses = 0;
    int re_samples = 0;
    int both_err = 0;
    int snap_we;
    int snap_re;

    rom_access_arbiter dut (
        .CLKSYS(clk), .RESET(rst),
        .CPU_REQ(cpu_req), .CPU_SEL(cpu_sel), .CPU_ADDR(cpu_addr),
        .CPU_DATA(cpu_data), .CPU_RDYn(cpu_rdyn),
        .DL_ACTIVE(dl_active), .DL_INDEX(dl_index), .DL_WR(dl_wr),
        .DL_ADDR(dl_addr), .DL_DATA(dl_data),
        .DL_WAIT(dl_wait), .DL_OVF(dl_ovf), .DL_COUNT(dl_count),
        .ROM_ADDR(rom_addr), .ROM_WDATA(rom_wdata), .ROM_WE(rom_we), .ROM_RE(rom_re),
        .ROM_Q0(q0), .ROM_Q1(q1), .ROM_Q2(q2)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst) begin
            if (rom_we != 3'b000) we_pulses++;
            if (rom_re != 3'b000) re_samples++;
            if (rom_we != 3'b000 && rom_re != 3'b000) both_err++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout obs=running exp=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        cpu_req = 0; cpu_sel = 0; cpu_addr = 0;
        dl_active = 0; dl_index = 0; dl_wr = 0; dl_addr = 0; dl_data = 0;
        q0 = 8'hA5; q1 = 8'h5A; q2 = 8'hC3;
        step(); step();
        chk("rst_rdyn", cpu_rdyn, 1);
        chk("rst_data", cpu_data, 0);
        chk("rst_we", rom_we, 0);
        chk("rst_re", rom_re, 0);
        chk("rst_addr", rom_addr, 0);
        chk("rst_wdata", rom_wdata, 0);
        chk("rst_wait", dl_wait, 0);
        chk("rst_ovf", dl_ovf, 0);
        chk("rst_count", dl_count, 0);
        rst = 1'b0;
        step();

        // basic BASIC ROM read
        cpu_sel = 0; cpu_addr = 15'h1234; cpu_req = 1;
        step();
        chk("rd_re", rom_re, 3'b001);
        chk("rd_addr", rom_addr, 15'h1234);
        chk("rd_rdyn_c1", cpu_rdyn, 1);
        step();
        chk("rd_re_wait", rom_re, 3'b001);
        chk("rd_rdyn_c2", cpu_rdyn, 1);
        step();
        chk("rd_rdyn_c3", cpu_rdyn, 0);
        chk("rd_data", cpu_data, 8'hA5);
        chk("rd_re_done", rom_re, 0);
        step();
        chk("rd_rdyn_hold", cpu_rdyn, 0);
        cpu_req = 0;
        step();
        chk("rd_rdyn_rel", cpu_rdyn, 1);
        chk("rd_data_hold", cpu_data, 8'hA5);

        // boot BAS read with address masked to 9 bits
        cpu_sel = 1; cpu_addr = 15'h7FFF; cpu_req = 1;
        step();
        chk("boot_re", rom_re, 3'b010);
        chk("boot_addr", rom_addr, 15'h01FF);
        step(); step();
        chk("boot_rdyn", cpu_rdyn, 0);
        chk("boot_data", cpu_data, 8'h5A);
        cpu_req = 0;
        step();

        // reset during RDWAIT, then restart
        cpu_sel = 2; cpu_addr = 15'h0003; cpu_req = 1;
        step(); step();
        chk("mid_re_wait", rom_re, 3'b100);
        rst = 1'b1;
        #1;
        chk("mid_rst_re", rom_re, 0);
        chk("mid_rst_rdyn", cpu_rdyn, 1);
        step();
        chk("mid_rst_data", cpu_data, 0);
        rst = 1'b0;
        step();
        chk("mid_restart_re", rom_re, 3'b100);
        chk("mid_restart_addr", rom_addr, 15'h0003);
        step();
        chk("mid_rdyn_c2", cpu_rdyn, 1);
        step();
        chk("mid_rdyn_c3", cpu_rdyn, 0);
        chk("mid_data", cpu_data, 8'hC3);
        cpu_req = 0;
        step();

        // unmapped select
        snap_re = re_samples;
        cpu_sel = 3; cpu_addr = 15'h0100; cpu_req = 1;
        step();
        chk("unm_rdyn_c1", cpu_rdyn, 1);
        step();
        chk("unm_rdyn_c2", cpu_rdyn, 0);
        chk("unm_data", cpu_data, 8'hFF);
        cpu_req = 0;
        step();
        chk("unm_rdyn_rel", cpu_rdyn, 1);
        chk("unm_no_re", re_samples - snap_re, 0);

        // collision with download window closed: write ignored
        snap_we = we_pulses;
        q0 = 8'h77;
        cpu_sel = 0; cpu_addr = 15'h0042; cpu_req = 1;
        dl_wr = 1; dl_index = 0; dl_addr = 15'h0005; dl_data = 8'h99;
        step();
        dl_wr = 0;
        chk("col0_re", rom_re, 3'b001);
        chk("col0_wait", dl_wait, 0);
        step(); step();
        chk("col0_data", cpu_data, 8'h77);
        cpu_req = 0;
        step(); step(); step();
        chk("col0_no_we", we_pulses - snap_we, 0);
        chk("col0_count", dl_count, 0);

        // collision with download window open: write first, CPU waits
        q0 = 8'h88;
        dl_active = 1; cpu_req = 1; cpu_sel = 0; cpu_addr = 15'h0043;
        dl_wr = 1; dl_index = 1; dl_addr = 15'h0010; dl_data = 8'h3C;
        step();
        dl_wr = 0;
        chk("col1_stall1", cpu_rdyn, 1);
        chk("col1_wait", dl_wait, 1);
        step();
        chk("col1_we", rom_we, 3'b010);
        chk("col1_waddr", rom_addr, 15'h0010);
        chk("col1_wdata", rom_wdata, 8'h3C);
        step();
        chk("col1_count", dl_count, 1);
        chk("col1_we_off", rom_we, 0);
        step();
        chk("col1_stall2", cpu_rdyn, 1);
        chk("col1_no_re", rom_re, 0);
        dl_active = 0;
        step();
        chk("col1_re", rom_re, 3'b001);
        chk("col1_raddr", rom_addr, 15'h0043);
        step(); step();
        chk("col1_rdyn", cpu_rdyn, 0);
        chk("col1_data", cpu_data, 8'h88);
        cpu_req = 0;
        step();

        // overflow while parked in RDDONE
        q2 = 8'hE1;
        cpu_sel = 2; cpu_addr = 15'h0010; cpu_req = 1;
        step(); step(); step();
        chk("ovf_rdone", cpu_rdyn, 0);
        dl_active = 1; dl_index = 0;
        dl_wr = 1; dl_addr = 15'h0100; dl_data = 8'hAA;
        step();
        chk("ovf_wait", dl_wait, 1);
        chk("ovf_clr", dl_ovf, 0);
        chk("ovf_cnt_clr", dl_count, 0);
        dl_addr = 15'h0101; dl_data = 8'hBB;
        step();
        chk("ovf_set1", dl_ovf, 1);
        dl_addr = 15'h0102; dl_data = 8'hCC;
        step();
        chk("ovf_set2", dl_ovf, 1);
        dl_wr = 0;
        step();
        chk("ovf_rd_hold", cpu_rdyn, 0);
        chk("ovf_no_we", rom_we, 0);
        cpu_req = 0;
        step();
        chk("ovf_rdyn_rel", cpu_rdyn, 1);
        step();
        chk("ovf_we", rom_we, 3'b001);
        chk("ovf_waddr", rom_addr, 15'h0100);
        chk("ovf_wdata", rom_wdata, 8'hAA);
        step();
        chk("ovf_count", dl_count, 1);
        chk("ovf_wait_clr", dl_wait, 0);
        chk("ovf_sticky", dl_ovf, 1);

        // 512-byte burst into boot DOS ROM, one strobe every two cycles
        dl_active = 0;
        step();
        snap_we = we_pulses;
        snap_re = re_samples;
        dl_active = 1; dl_index = 2;
        for (int i = 0; i < 512; i++) begin
            dl_wr = 1; dl_addr = 15'(i); dl_data = i[7:0];
            chk("burst_wait", dl_wait, 0);
            step();
            dl_wr = 0;
            step();
            chk("burst_wr", {rom_we, rom_wdata, rom_addr}, {3'b100, i[7:0], 15'(i)});
        end
        step();
        chk("burst_count", dl_count, 512);
        chk("burst_ovf", dl_ovf, 0);
        chk("burst_pulses", we_pulses - snap_we, 512);
        chk("burst_no_re", re_samples - snap_re, 0);
        dl_active = 0;
        step();

        chk("we_re_exclusive", both_err, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
